// File: rtl/pc_sequencer_if.sv
// Bundle of signals between pc_sequencer and its surroundings: IF stage, hazard unit, ID resolution and debug control.
// The slave modport is the sequencer's view; the master modport drives the inputs and observes the outputs.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_cur;
  logic              start;
  logic              step_mode;
  logic              step_req;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              halt_detect;
  logic              pc_enable;
  logic [ADDR_W-1:0] pc_next;
  logic              flush_if;
  logic              running;
  logic              halted;
  logic [31:0]       cycle_count;

  modport master (
    output pc_cur, start, step_mode, step_req, stall,
           branch_taken, branch_target, jump, jump_target, halt_detect,
    input  pc_enable, pc_next, flush_if, running, halted, cycle_count
  );

  modport slave (
    input  pc_cur, start, step_mode, step_req, stall,
           branch_taken, branch_target, jump, jump_target, halt_detect,
    output pc_enable, pc_next, flush_if, running, halted, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: drives enable/next-address of an unreset PC register, with run, single-step, halt and drain.
// Optional active-cycle counter enabled by defining PCSEQ_CYCLE_CNT_EN; otherwise cycle_count is tied to 0.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for start, no PC updates
// RUN     | continuous fetch, one PC update per unstalled cycle
// STEP    | debug mode, one PC update per step_req rising edge
// DRAIN   | HALT fetched, letting the pipeline empty for DRAIN_CYCLES
// HALTED  | stopped until reset
module pc_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                PC_INC       = 4,
  parameter int                DRAIN_CYCLES = 4
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic             step_req_q, step_req_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic              grant;
  logic              step_edge;
  logic              running;
  logic [ADDR_W-1:0] pc_seq;

  assign step_edge = bus.step_req & ~step_req_q;
  assign pc_seq    = bus.pc_cur + ADDR_W'(PC_INC);

  always_comb begin
    state_d     = state_q;
    step_req_d  = bus.step_req;
    pending_d   = pending_q;
    drain_cnt_d = drain_cnt_q;
    grant       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = bus.step_mode ? S_STEP : S_RUN;
      end
      S_RUN: begin
        grant = ~bus.stall & ~bus.halt_detect;
        if (bus.halt_detect && !bus.stall) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      S_STEP: begin
        grant = pending_q & ~bus.stall & ~bus.halt_detect;
        // Edges arriving while a step is already pending are absorbed.
        if (grant) pending_d = 1'b0;
        else if (step_edge) pending_d = 1'b1;
        if (bus.halt_detect && !bus.stall) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
          pending_d   = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d = S_HALTED;
        else drain_cnt_d = drain_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_req_q  <= 1'b0;
      pending_q   <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_req_q  <= step_req_d;
      pending_q   <= pending_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Reset overrides everything so the unreset PC register loads the vector.
  always_comb begin
    bus.pc_enable = 1'b0;
    bus.pc_next   = pc_seq;
    bus.flush_if  = 1'b0;
    if (reset) begin
      bus.pc_enable = 1'b1;
      bus.pc_next   = RESET_VECTOR;
    end else if (grant) begin
      bus.pc_enable = 1'b1;
      bus.flush_if  = bus.branch_taken | bus.jump;
      if (bus.branch_taken) bus.pc_next = bus.branch_target;
      else if (bus.jump)    bus.pc_next = bus.jump_target;
    end
  end

  assign running     = ~reset & ((state_q == S_RUN) | (state_q == S_STEP) | (state_q == S_DRAIN));
  assign bus.running = running;
  assign bus.halted  = ~reset & (state_q == S_HALTED);

`ifdef PCSEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (running) cycle_cnt_d = cycle_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt_q <= '0;
    else       cycle_cnt_q <= cycle_cnt_d;
  end

  assign bus.cycle_count = cycle_cnt_q;
`else
  assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer, checked every cycle against a mode-level model.
// Honours PCSEQ_CYCLE_CNT_EN the same way as the design when checking cycle_count.
module tb_pc_sequencer;
  localparam logic [31:0] RV     = 32'h0000_0100;
  localparam int          DRAIN  = 4;

  typedef enum int {M_IDLE, M_RUN, M_STEP, M_DRAIN, M_HALTED} mode_t;

  logic clk;
  logic reset;
  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(.ADDR_W(32), .RESET_VECTOR(RV), .PC_INC(4), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  mode_t       m_mode = M_IDLE;
  bit          m_pend = 0;
  int          m_rem = 0;
  logic [31:0] m_cyc = 0;
  bit          m_prev_req = 0;
  bit          exp_en;
  logic [31:0] exp_next;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs straight from the rules, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit grant, exp_flush, exp_run, exp_halt;
      logic [31:0] exp_cc;
      case (m_mode)
        M_RUN:   grant = !bus.stall && !bus.halt_detect;
        M_STEP:  grant = m_pend && !bus.stall && !bus.halt_detect;
        default: grant = 0;
      endcase
      if (reset) begin
        exp_en = 1; exp_next = RV; exp_flush = 0; exp_run = 0; exp_halt = 0;
      end else begin
        exp_en    = grant;
        exp_next  = bus.pc_cur + 32'd4;
        if (grant && bus.branch_taken) exp_next = bus.branch_target;
        else if (grant && bus.jump)    exp_next = bus.jump_target;
        exp_flush = grant && (bus.branch_taken || bus.jump);
        exp_run   = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
        exp_halt  = (m_mode == M_HALTED);
      end
`ifdef PCSEQ_CYCLE_CNT_EN
      exp_cc = m_cyc;
`else
      exp_cc = 0;
`endif
      check("pc_enable",   32'(bus.pc_enable), 32'(exp_en));
      check("pc_next",     bus.pc_next,        exp_next);
      check("flush_if",    32'(bus.flush_if),  32'(exp_flush));
      check("running",     32'(bus.running),   32'(exp_run));
      check("halted",      32'(bus.halted),    32'(exp_halt));
      check("cycle_count", bus.cycle_count,    exp_cc);
    end
  end

  // Model advance plus the PC register itself.
  always @(posedge clk) begin
    if (chk_en) begin
      if (reset) begin
        m_mode = M_IDLE; m_pend = 0; m_rem = 0; m_cyc = 0; m_prev_req = 0;
      end else begin
        bit edge_seen;
        if (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN) m_cyc = m_cyc + 1;
        edge_seen  = bus.step_req && !m_prev_req;
        m_prev_req = bus.step_req;
        case (m_mode)
          M_IDLE: if (bus.start) m_mode = bus.step_mode ? M_STEP : M_RUN;
          M_RUN:  if (bus.halt_detect && !bus.stall) begin m_mode = M_DRAIN; m_rem = DRAIN; end
          M_STEP: begin
            if (exp_en) m_pend = 0;
            else if (edge_seen) m_pend = 1;
            if (bus.halt_detect && !bus.stall) begin m_mode = M_DRAIN; m_rem = DRAIN; m_pend = 0; end
          end
          M_DRAIN: begin
            m_rem--;
            if (m_rem == 0) m_mode = M_HALTED;
          end
          default: ;
        endcase
      end
      if (exp_en) bus.pc_cur = exp_next;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.step_mode = 0; bus.step_req = 0; bus.stall = 0;
    bus.branch_taken = 0; bus.branch_target = 0; bus.jump = 0; bus.jump_target = 0;
    bus.halt_detect = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 0;
  endtask

  task automatic random_cycles(input int n, input bit stepping);
    for (int i = 0; i < n; i++) begin
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.branch_taken  = ($urandom_range(0, 4) == 0);
      bus.jump          = ($urandom_range(0, 4) == 0);
      bus.branch_target = $urandom & 32'hFFFF_FFFC;
      bus.jump_target   = $urandom & 32'hFFFF_FFFC;
      if (stepping) bus.step_req = ($urandom_range(0, 2) == 0) ? ~bus.step_req : bus.step_req;
      tick();
    end
  endtask

  initial begin
    int n_en;
    int n_run;
    bus.pc_cur = 0;
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    chk_en = 1;
    #1;
    check("rst_enable", 32'(bus.pc_enable), 32'd1);
    check("rst_vector", bus.pc_next, 32'h100);
    tick();
    reset = 0;
    #1;
    check("idle_enable", 32'(bus.pc_enable), 32'd0);
    check("idle_halted", 32'(bus.halted), 32'd0);

    bus.start = 1; bus.step_mode = 0;
    tick();
    bus.pc_cur = 32'h0;
    #1;
    check("run_seq0", bus.pc_next, 32'h4);
    tick(); #1;
    check("run_seq1", bus.pc_next, 32'h8);
    bus.branch_taken = 1; bus.branch_target = 32'h40;
    #1;
    check("branch_next", bus.pc_next, 32'h40);
    check("branch_flush", 32'(bus.flush_if), 32'd1);
    tick();
    bus.jump = 1; bus.jump_target = 32'h80;
    #1;
    check("branch_over_jump", bus.pc_next, 32'h40);
    tick();
    bus.branch_taken = 0; bus.jump = 0;

    bus.pc_cur = 32'h10;
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_enable", 32'(bus.pc_enable), 32'd0);
      check("stall_flush", 32'(bus.flush_if), 32'd0);
      tick();
    end
    bus.stall = 0;
    #1;
    check("post_stall_next", bus.pc_next, 32'h200);
    check("post_stall_flush", 32'(bus.flush_if), 32'd1);
    tick();
    bus.branch_taken = 0;

    random_cycles(300, 0);
    clear_inputs();

    do_reset(1);
    bus.start = 1; bus.step_mode = 1;
    tick();
    bus.start = 0;
    n_en = 0;
    bus.step_req = 1;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (bus.pc_enable) n_en++;
      tick();
    end
    check("step_held_updates", n_en, 1);
    bus.step_req = 0;
    tick();
    bus.stall = 1; bus.step_req = 1;
    n_en = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.pc_enable) n_en++;
      tick();
    end
    check("step_stalled_updates", n_en, 0);
    bus.stall = 0;
    n_en = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.pc_enable) n_en++;
      tick();
    end
    check("step_deferred_updates", n_en, 1);

    random_cycles(300, 1);
    clear_inputs();

    do_reset(1);
    bus.start = 1;
    tick();
    bus.pc_cur = 32'h20; bus.halt_detect = 1;
    #1;
    check("halt_enable", 32'(bus.pc_enable), 32'd0);
    n_run = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (bus.halted) break;
      if (bus.running) n_run++;
    end
    check("drain_cycles", n_run, DRAIN);
    check("halted_set", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    #1;
    check("halted_sticky", 32'(bus.halted), 32'd1);
    check("halted_pc", bus.pc_cur, 32'h20);

    do_reset(1);
    tick();
    bus.pc_cur = 32'h20;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0; bus.halt_detect = 0; bus.start = 0;
    #1;
    check("mid_drain_running", 32'(bus.running), 32'd0);
    check("mid_drain_halted", 32'(bus.halted), 32'd0);
    check("mid_drain_cycles", bus.cycle_count, 32'd0);
    bus.start = 1;
    tick();
    bus.pc_cur = 32'hFFFF_FFFC;
    #1;
    check("wrap_next", bus.pc_next, 32'h0);
    check("wrap_enable", 32'(bus.pc_enable), 32'd1);
    tick();
    bus.start = 0;
    random_cycles(100, 0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
